// File: rtl/uart_tx_arbiter.sv
// rtl/uart_tx_arbiter.sv - three-way packet-locked round-robin arbiter feeding one UART transmitter
module uart_tx_arbiter #(
  parameter int IDLE_MAX = 1000,
  parameter int CNT_W    = 10
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [2:0]  req_vld,
  input  logic [23:0] req_dat,
  input  logic [2:0]  req_last,
  output logic [2:0]  req_rdy,
  output logic [7:0]  d_tx,
  output logic        vld_tx,
  input  logic        rdy_tx,
  output logic [2:0]  grant,
  output logic        err_timeout,
  output logic [1:0]  err_id,
  output logic [15:0] pkt_cnt
);

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [2:0]       grant_nxt;
  logic [1:0]       g_idx;
  logic [1:0]       g_idx_nxt;
  logic [1:0]       ptr;
  logic [1:0]       ptr_nxt;
  logic [CNT_W-1:0] stall_cnt;

  logic       winner_found;
  logic [1:0] winner;
  logic       vld_g;
  logic       last_g;
  logic [7:0] dat_g;
  logic       slot_open;
  logic       accept;
  logic       stall;
  logic       timeout;
  logic       pkt_done;

  // Round-robin search starting at ptr; only consulted while idle
  always_comb begin
    winner_found = |req_vld;
    winner       = 2'd0;
    case (ptr)
      2'd1:    winner = req_vld[1] ? 2'd1 : (req_vld[2] ? 2'd2 : 2'd0);
      2'd2:    winner = req_vld[2] ? 2'd2 : (req_vld[0] ? 2'd0 : 2'd1);
      default: winner = req_vld[0] ? 2'd0 : (req_vld[1] ? 2'd1 : 2'd2);
    endcase
  end

  // Select the granted requester's lane; grant is one-hot so AND-OR is enough for the flags
  always_comb begin
    vld_g  = |(req_vld & grant);
    last_g = |(req_last & grant);
    dat_g  = 8'h00;
    case (g_idx)
      2'd0:    dat_g = req_dat[7:0];
      2'd1:    dat_g = req_dat[15:8];
      2'd2:    dat_g = req_dat[23:16];
      default: dat_g = 8'h00;
    endcase
  end

  // Handshake and stall detection; the output slot is free when empty or draining this cycle
  always_comb begin
    slot_open = !vld_tx || rdy_tx;
    req_rdy   = 3'b000;
    if (state == BUSY && slot_open && !rst) begin
      req_rdy = grant;
    end
    accept   = |(req_rdy & req_vld);
    pkt_done = accept && last_g;
    stall    = (state == BUSY) && slot_open && !vld_g && !rst;
    timeout  = stall && (stall_cnt == CNT_W'(IDLE_MAX - 1));
  end

  // Next-state logic: arbitrate in IDLE, hold the grant until last byte or stall timeout
  always_comb begin
    state_nxt = state;
    grant_nxt = grant;
    g_idx_nxt = g_idx;
    ptr_nxt   = ptr;
    case (state)
      IDLE: begin
        if (winner_found) begin
          state_nxt = BUSY;
          grant_nxt = 3'b001 << winner;
          g_idx_nxt = winner;
          ptr_nxt   = (winner == 2'd2) ? 2'd0 : winner + 2'd1;
        end
      end
      BUSY: begin
        if (pkt_done || timeout) begin
          state_nxt = IDLE;
          grant_nxt = 3'b000;
        end
      end
      default: begin
        state_nxt = IDLE;
        grant_nxt = 3'b000;
      end
    endcase
  end

  // State, grant and priority pointer registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      grant <= 3'b000;
      g_idx <= 2'd0;
      ptr   <= 2'd0;
    end else begin
      state <= state_nxt;
      grant <= grant_nxt;
      g_idx <= g_idx_nxt;
      ptr   <= ptr_nxt;
    end
  end

  // Stall counter: zero while idle so every new grant starts fresh; frozen under back-pressure
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt <= '0;
    end else if (state == IDLE || accept || timeout) begin
      stall_cnt <= '0;
    end else if (stall) begin
      stall_cnt <= stall_cnt + CNT_W'(1);
    end
  end

  // Output byte register; a load and a drain in the same cycle keep vld_tx high
  always_ff @(posedge clk) begin
    if (rst) begin
      d_tx   <= 8'h00;
      vld_tx <= 1'b0;
    end else if (accept) begin
      d_tx   <= dat_g;
      vld_tx <= 1'b1;
    end else if (vld_tx && rdy_tx) begin
      vld_tx <= 1'b0;
    end
  end

  // Timeout reporting: single-cycle pulse, offender index held until the next timeout
  always_ff @(posedge clk) begin
    if (rst) begin
      err_timeout <= 1'b0;
      err_id      <= 2'd0;
    end else begin
      err_timeout <= timeout;
      if (timeout) begin
        err_id <= g_idx;
      end
    end
  end

  // Completed-packet counter, free-running wrap at 16 bits
  always_ff @(posedge clk) begin
    if (rst) begin
      pkt_cnt <= 16'd0;
    end else if (pkt_done) begin
      pkt_cnt <= pkt_cnt + 16'd1;
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb/tb_uart_tx_arbiter.sv - directed vector bench for uart_tx_arbiter
module tb_uart_tx_arbiter;

  logic        clk;
  logic        rst;
  logic [2:0]  req_vld;
  logic [23:0] req_dat;
  logic [2:0]  req_last;
  logic [2:0]  req_rdy;
  logic [7:0]  d_tx;
  logic        vld_tx;
  logic        rdy_tx;
  logic [2:0]  grant;
  logic        err_timeout;
  logic [1:0]  err_id;
  logic [15:0] pkt_cnt;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        rst;
    logic [2:0]  vld;
    logic [23:0] dat;
    logic [2:0]  last;
    logic        rdy_tx;
    logic [2:0]  e_rdy;
    logic [7:0]  e_dtx;
    logic        e_vtx;
    logic [2:0]  e_gnt;
    logic        e_to;
    logic [1:0]  e_eid;
    logic [15:0] e_pcnt;
  } vec_t;

  vec_t tbl[$];

  uart_tx_arbiter #(.IDLE_MAX(4), .CNT_W(3)) dut (
    .clk(clk),
    .rst(rst),
    .req_vld(req_vld),
    .req_dat(req_dat),
    .req_last(req_last),
    .req_rdy(req_rdy),
    .d_tx(d_tx),
    .vld_tx(vld_tx),
    .rdy_tx(rdy_tx),
    .grant(grant),
    .err_timeout(err_timeout),
    .err_id(err_id),
    .pkt_cnt(pkt_cnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog act=running exp=finished");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%0h exp=%0h", name, act, exp);
    end
  endtask

  task automatic add(input logic r, input logic [2:0] v, input logic [23:0] d, input logic [2:0] l,
                     input logic rt, input logic [2:0] er, input logic [7:0] ed, input logic ev,
                     input logic [2:0] eg, input logic eto, input logic [1:0] ee, input logic [15:0] ep);
    vec_t t;
    t.rst = r; t.vld = v; t.dat = d; t.last = l; t.rdy_tx = rt;
    t.e_rdy = er; t.e_dtx = ed; t.e_vtx = ev; t.e_gnt = eg;
    t.e_to = eto; t.e_eid = ee; t.e_pcnt = ep;
    tbl.push_back(t);
  endtask

  task automatic drive(input logic [2:0] v, input logic [23:0] d, input logic [2:0] l);
    req_vld  = v;
    req_dat  = d;
    req_last = l;
  endtask

  initial begin
    logic got;
    rst = 1'b1; req_vld = 3'b000; req_dat = 24'h0; req_last = 3'b000; rdy_tx = 1'b1;

    // round robin from reset, 1-byte packets
    add(0, 3'b111, 24'hC2B1A0, 3'b111, 1, 3'b000, 8'h00, 0, 3'b000, 0, 2'd0, 16'd0);
    add(0, 3'b111, 24'hC2B1A0, 3'b111, 1, 3'b001, 8'h00, 0, 3'b001, 0, 2'd0, 16'd0);
    add(0, 3'b111, 24'hC2B1A0, 3'b111, 1, 3'b000, 8'hA0, 1, 3'b000, 0, 2'd0, 16'd1);
    add(0, 3'b111, 24'hC2B1A0, 3'b111, 1, 3'b010, 8'hA0, 0, 3'b010, 0, 2'd0, 16'd1);
    add(0, 3'b111, 24'hC2B1A0, 3'b111, 1, 3'b000, 8'hB1, 1, 3'b000, 0, 2'd0, 16'd2);
    add(0, 3'b111, 24'hC2B1A0, 3'b111, 1, 3'b100, 8'hB1, 0, 3'b100, 0, 2'd0, 16'd2);
    add(0, 3'b111, 24'hC2B1A0, 3'b111, 1, 3'b000, 8'hC2, 1, 3'b000, 0, 2'd0, 16'd3);
    add(0, 3'b111, 24'hC2B1A0, 3'b111, 1, 3'b001, 8'hC2, 0, 3'b001, 0, 2'd0, 16'd3);
    add(0, 3'b000, 24'h000000, 3'b000, 1, 3'b000, 8'hA0, 1, 3'b000, 0, 2'd0, 16'd4);
    // single packet from requester 1: 0x41, 0x42(last)
    add(0, 3'b010, 24'h004100, 3'b000, 1, 3'b000, 8'hA0, 0, 3'b000, 0, 2'd0, 16'd4);
    add(0, 3'b010, 24'h004100, 3'b000, 1, 3'b010, 8'hA0, 0, 3'b010, 0, 2'd0, 16'd4);
    add(0, 3'b010, 24'h004200, 3'b010, 1, 3'b010, 8'h41, 1, 3'b010, 0, 2'd0, 16'd4);
    add(0, 3'b000, 24'h000000, 3'b000, 1, 3'b000, 8'h42, 1, 3'b000, 0, 2'd0, 16'd5);
    add(0, 3'b000, 24'h000000, 3'b000, 1, 3'b000, 8'h42, 0, 3'b000, 0, 2'd0, 16'd5);
    // back-pressure for 5 cycles mid-packet, requester 2
    add(0, 3'b100, 24'h510000, 3'b000, 1, 3'b000, 8'h42, 0, 3'b000, 0, 2'd0, 16'd5);
    add(0, 3'b100, 24'h510000, 3'b000, 1, 3'b100, 8'h42, 0, 3'b100, 0, 2'd0, 16'd5);
    for (int k = 0; k < 5; k++)
      add(0, 3'b100, 24'h520000, 3'b000, 0, 3'b000, 8'h51, 1, 3'b100, 0, 2'd0, 16'd5);
    add(0, 3'b100, 24'h520000, 3'b000, 1, 3'b100, 8'h51, 1, 3'b100, 0, 2'd0, 16'd5);
    add(0, 3'b100, 24'h530000, 3'b100, 1, 3'b100, 8'h52, 1, 3'b100, 0, 2'd0, 16'd5);
    add(0, 3'b000, 24'h000000, 3'b000, 1, 3'b000, 8'h53, 1, 3'b000, 0, 2'd0, 16'd6);
    // no pre-emption: requester 0 waits for requester 2's last byte
    add(0, 3'b100, 24'h610000, 3'b000, 1, 3'b000, 8'h53, 0, 3'b000, 0, 2'd0, 16'd6);
    add(0, 3'b101, 24'h610070, 3'b000, 1, 3'b100, 8'h53, 0, 3'b100, 0, 2'd0, 16'd6);
    add(0, 3'b101, 24'h620070, 3'b100, 1, 3'b100, 8'h61, 1, 3'b100, 0, 2'd0, 16'd6);
    add(0, 3'b001, 24'h000070, 3'b001, 1, 3'b000, 8'h62, 1, 3'b000, 0, 2'd0, 16'd7);
    add(0, 3'b001, 24'h000070, 3'b001, 1, 3'b001, 8'h62, 0, 3'b001, 0, 2'd0, 16'd7);
    add(0, 3'b000, 24'h000000, 3'b000, 1, 3'b000, 8'h70, 1, 3'b000, 0, 2'd0, 16'd8);
    // stall timeout: requester 2 sends 0x10 then goes quiet for 4 cycles
    add(0, 3'b100, 24'h100000, 3'b000, 1, 3'b000, 8'h70, 0, 3'b000, 0, 2'd0, 16'd8);
    add(0, 3'b100, 24'h100000, 3'b000, 1, 3'b100, 8'h70, 0, 3'b100, 0, 2'd0, 16'd8);
    add(0, 3'b000, 24'h000000, 3'b000, 1, 3'b100, 8'h10, 1, 3'b100, 0, 2'd0, 16'd8);
    for (int k = 0; k < 3; k++)
      add(0, 3'b000, 24'h000000, 3'b000, 1, 3'b100, 8'h10, 0, 3'b100, 0, 2'd0, 16'd8);
    add(0, 3'b000, 24'h000000, 3'b000, 1, 3'b000, 8'h10, 0, 3'b000, 1, 2'd2, 16'd8);
    add(0, 3'b000, 24'h000000, 3'b000, 1, 3'b000, 8'h10, 0, 3'b000, 0, 2'd2, 16'd8);
    // reset in the middle of a 3-byte packet, then requester 0 wins the tie
    add(0, 3'b010, 24'h008100, 3'b000, 1, 3'b000, 8'h10, 0, 3'b000, 0, 2'd2, 16'd8);
    add(0, 3'b010, 24'h008100, 3'b000, 1, 3'b010, 8'h10, 0, 3'b010, 0, 2'd2, 16'd8);
    add(1, 3'b010, 24'h008200, 3'b000, 1, 3'b000, 8'h81, 1, 3'b010, 0, 2'd2, 16'd8);
    add(0, 3'b111, 24'hC2B1A0, 3'b111, 1, 3'b000, 8'h00, 0, 3'b000, 0, 2'd0, 16'd0);
    add(0, 3'b111, 24'hC2B1A0, 3'b111, 1, 3'b001, 8'h00, 0, 3'b001, 0, 2'd0, 16'd0);
    add(0, 3'b000, 24'h000000, 3'b000, 1, 3'b000, 8'hA0, 1, 3'b000, 0, 2'd0, 16'd1);

    @(negedge clk);
    @(negedge clk);

    foreach (tbl[i]) begin
      @(negedge clk);
      rst    = tbl[i].rst;
      rdy_tx = tbl[i].rdy_tx;
      drive(tbl[i].vld, tbl[i].dat, tbl[i].last);
      #1;
      chk($sformatf("row%0d_req_rdy", i), 32'(req_rdy), 32'(tbl[i].e_rdy));
      chk($sformatf("row%0d_d_tx", i), 32'(d_tx), 32'(tbl[i].e_dtx));
      chk($sformatf("row%0d_vld_tx", i), 32'(vld_tx), 32'(tbl[i].e_vtx));
      chk($sformatf("row%0d_grant", i), 32'(grant), 32'(tbl[i].e_gnt));
      chk($sformatf("row%0d_err_timeout", i), 32'(err_timeout), 32'(tbl[i].e_to));
      chk($sformatf("row%0d_err_id", i), 32'(err_id), 32'(tbl[i].e_eid));
      chk($sformatf("row%0d_pkt_cnt", i), 32'(pkt_cnt), 32'(tbl[i].e_pcnt));
    end

    // streaming with stalls just under the limit; each accepted byte restarts the count
    @(negedge clk);
    rst = 1'b0; rdy_tx = 1'b1;
    drive(3'b001, 24'h0000D0, 3'b000);
    got = 1'b0;
    for (int i = 0; i < 10 && !got; i++) begin
      @(negedge clk);
      #1;
      if (grant == 3'b001) got = 1'b1;
    end
    chk("seq_grant_wait", 32'(got), 32'd1);
    @(negedge clk); #1;
    chk("seq_d0", 32'(d_tx), 32'hD0);
    drive(3'b001, 24'h0000D1, 3'b000);
    @(negedge clk); #1;
    chk("seq_d1", 32'(d_tx), 32'hD1);
    chk("seq_d1_vld", 32'(vld_tx), 32'd1);
    drive(3'b000, 24'h0000D1, 3'b000);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk); #1;
      chk("seq_stall_a_to", 32'(err_timeout), 32'd0);
      chk("seq_stall_a_grant", 32'(grant), 32'b001);
    end
    drive(3'b001, 24'h0000D2, 3'b000);
    @(negedge clk); #1;
    chk("seq_d2", 32'(d_tx), 32'hD2);
    chk("seq_d2_grant", 32'(grant), 32'b001);
    drive(3'b000, 24'h0000D2, 3'b000);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk); #1;
      chk("seq_stall_b_to", 32'(err_timeout), 32'd0);
      chk("seq_stall_b_grant", 32'(grant), 32'b001);
    end
    drive(3'b001, 24'h0000D3, 3'b001);
    @(negedge clk); #1;
    chk("seq_d3", 32'(d_tx), 32'hD3);
    chk("seq_d3_grant", 32'(grant), 32'b000);
    chk("seq_d3_pkt_cnt", 32'(pkt_cnt), 32'd2);
    chk("seq_d3_to", 32'(err_timeout), 32'd0);
    drive(3'b000, 24'h000000, 3'b000);
    @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
